data_mem_responder: RTL

//  Data-memory responder for the 16-bit single-cycle CPU's LW/SW path; the CPU side issues requests, this block answers.

---
 rtl/data_mem_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Word-organised data memory answering CPU LW/SW requests over a req/ack handshake,
// with programmable wait states and misaligned-access flagging.
module data_mem_responder #(
  parameter int AW          = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state_r;
  logic [3:0]    cnt_r;
  logic          we_r;
  logic [15:0]   addr_r;
  logic [15:0]   wdata_r;
  logic [15:0]   ld_r;
  logic [15:0]   mem_r [0:(1<<AW)-1];

  logic          op_we_s;
  logic [15:0]   op_addr_s;
  logic [15:0]   op_wdata_s;
  logic [AW-1:0] idx_s;
  logic          enter_resp_s;
  logic          mem_we_s;
  logic [15:0]   load_data_s;
  logic          unused_addr_s;

  // Select the operation being completed: live inputs when accepted straight from IDLE, latched copies otherwise
  always_comb begin
    op_we_s      = we_r;
    op_addr_s    = addr_r;
    op_wdata_s   = wdata_r;
    enter_resp_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        op_we_s    = we;
        op_addr_s  = addr;
        op_wdata_s = wdata;
        if (req && (WAIT_STATES == 0)) begin
          enter_resp_s = 1'b1;
        end else begin
          enter_resp_s = 1'b0;
        end
      end
      S_WAIT: begin
        if (cnt_r == 4'd0) begin
          enter_resp_s = 1'b1;
        end else begin
          enter_resp_s = 1'b0;
        end
      end
      default: enter_resp_s = 1'b0;
    endcase
    idx_s       = op_addr_s[AW:1];
    mem_we_s    = enter_resp_s && op_we_s && !op_addr_s[0] && !reset;
    load_data_s = (!op_we_s && !op_addr_s[0]) ? mem_r[idx_s] : 16'd0;
  end

  // High address bits alias onto the RAM and are deliberately ignored
  assign unused_addr_s = ^op_addr_s[15:AW+1];

  // RAM write port; contents survive reset
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem_r[idx_s] <= op_wdata_s;
    end
  end

  // Handshake FSM with registered response outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      addr_r  <= 16'd0;
      wdata_r <= 16'd0;
      ld_r    <= 16'd0;
      rdata   <= 16'd0;
      ack     <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= 16'd0;
      if (enter_resp_s) begin
        ld_r <= load_data_s;
      end
      case (state_r)
        S_IDLE: begin
          if (req) begin
            we_r    <= we;
            addr_r  <= addr;
            wdata_r <= wdata;
            busy    <= 1'b1;
            if (WAIT_STATES == 0) begin
              state_r <= S_RESP;
            end else begin
              state_r <= S_WAIT;
              cnt_r   <= 4'(WAIT_STATES - 1);
            end
          end else begin
            busy <= 1'b0;
          end
        end
        S_WAIT: begin
          busy <= 1'b1;
          if (cnt_r == 4'd0) begin
            state_r <= S_RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_RESP: begin
          // Load data was captured on entry; misaligned accesses return zero with err
          state_r <= S_IDLE;
          ack     <= 1'b1;
          err     <= addr_r[0];
          rdata   <= ld_r;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
